// File: rtl/multiples_pkg.sv
// Shared parameters and helpers for the multiples FIFO storage and its controller.
// Used by multiples_slot_ptr and multiples_ctrl (optional flush: MULTIPLES_CTRL_FLUSH_EN).
package multiples_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int DEPTH       = 10;
  localparam int ADDR_WIDTH  = 4;
  localparam int COUNT_WIDTH = 4;

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_e;

  typedef struct packed {
    logic full;
    logic empty;
  } occ_flags_t;

  // Out-of-range slots recover to the first slot rather than running off the map.
  function automatic logic [ADDR_WIDTH-1:0] next_slot(input logic [ADDR_WIDTH-1:0] slot);
    logic [ADDR_WIDTH-1:0] nxt;
    if ((slot >= LAST_ADDR) || (slot < BASE_ADDR)) begin
      nxt = BASE_ADDR;
    end else begin
      nxt = slot + ADDR_WIDTH'(1);
    end
    return nxt;
  endfunction

  function automatic occ_flags_t occ_flags(input logic [COUNT_WIDTH-1:0] cnt);
    occ_flags_t f;
    f.full  = (cnt == COUNT_WIDTH'(DEPTH));
    f.empty = (cnt == {COUNT_WIDTH{1'b0}});
    return f;
  endfunction

endpackage

// File: rtl/multiples_slot_ptr.sv
// Wrapping storage slot pointer (BASE_ADDR..LAST_ADDR), used for both write and read sides.
module multiples_slot_ptr
  import multiples_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] slot
);

  logic [ADDR_WIDTH-1:0] slot_r;

  // Pointer register: clear has priority over advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_r <= BASE_ADDR;
    end else if (clear) begin
      slot_r <= BASE_ADDR;
    end else if (advance) begin
      slot_r <= next_slot(slot_r);
    end else begin
      slot_r <= slot_r;
    end
  end

  assign slot = slot_r;

endmodule

// File: rtl/multiples_ctrl.sv
// Pointer/handshake controller for the 10-slot multiples FIFO; storage is external.
// Optional synchronous flush port enabled by MULTIPLES_CTRL_FLUSH_EN.
module multiples_ctrl
  import multiples_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
`ifdef MULTIPLES_CTRL_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   fifo_write_enable,
  output logic [ADDR_WIDTH-1:0]  fifo_write_address,
  output logic [DATA_WIDTH-1:0]  fifo_input_data,
  output logic [ADDR_WIDTH-1:0]  fifo_read_address,
  input  logic [DATA_WIDTH-1:0]  fifo_output_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty
);

  logic                   flush_s;
  logic                   push_s;
  logic                   pop_s;
  occ_flags_t             flags_s;
  occ_op_e                occ_op_s;
  logic [COUNT_WIDTH-1:0] count_r;
  logic [ADDR_WIDTH-1:0]  wr_slot_s;
  logic [ADDR_WIDTH-1:0]  rd_slot_s;

`ifdef MULTIPLES_CTRL_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake depends only on registered occupancy; reset also blocks the write strobe.
  assign flags_s   = occ_flags(count_r);
  assign in_ready  = ~flags_s.full;
  assign out_valid = ~flags_s.empty;
  assign push_s    = in_valid & in_ready & ~flush_s & ~reset;
  assign pop_s     = out_valid & out_ready & ~flush_s;

  // Occupancy update selection.
  always_comb begin
    occ_op_s = OCC_HOLD;
    case ({push_s, pop_s})
      2'b10:   occ_op_s = OCC_INC;
      2'b01:   occ_op_s = OCC_DEC;
      default: occ_op_s = OCC_HOLD;
    endcase
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {COUNT_WIDTH{1'b0}};
    end else if (flush_s) begin
      count_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      case (occ_op_s)
        OCC_INC: count_r <= count_r + COUNT_WIDTH'(1);
        OCC_DEC: count_r <= count_r - COUNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  multiples_slot_ptr u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush_s),
    .advance (push_s),
    .slot    (wr_slot_s)
  );

  multiples_slot_ptr u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush_s),
    .advance (pop_s),
    .slot    (rd_slot_s)
  );

  assign fifo_write_enable  = push_s;
  assign fifo_write_address = wr_slot_s;
  assign fifo_input_data    = in_data;
  assign fifo_read_address  = rd_slot_s;
  assign out_data           = fifo_output_data;
  assign count              = count_r;
  assign full               = flags_s.full;
  assign empty              = flags_s.empty;

endmodule

// File: tb/tb_multiples_ctrl.sv
// Self-checking bench for multiples_ctrl: vector table, directed corners, random traffic vs queue model.
module tb_multiples_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_tb;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        fifo_write_enable;
  logic [3:0]  fifo_write_address;
  logic [31:0] fifo_input_data;
  logic [3:0]  fifo_read_address;
  logic [31:0] fifo_output_data;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words plus totals of writes/reads.
  logic [31:0] q[$];
  int          wr_n;
  int          rd_n;

  // External storage stand-in.
  logic [31:0] mem [0:15];

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] data;
    logic        exp_we;
    logic [3:0]  exp_waddr;
    logic [3:0]  exp_raddr;
    logic        exp_ovalid;
    logic [31:0] exp_odata;
    logic [3:0]  exp_count;
    logic        exp_full;
  } vec_t;

  vec_t vecs[21];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_write_enable) mem[fifo_write_address] <= fifo_input_data;
  end
  assign fifo_output_data = mem[fifo_read_address];

  multiples_ctrl dut (
    .clk                (clk),
    .reset              (reset),
`ifdef MULTIPLES_CTRL_FLUSH_EN
    .flush              (flush_tb),
`endif
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .fifo_write_enable  (fifo_write_enable),
    .fifo_write_address (fifo_write_address),
    .fifo_input_data    (fifo_input_data),
    .fifo_read_address  (fifo_read_address),
    .fifo_output_data   (fifo_output_data),
    .count              (count),
    .full               (full),
    .empty              (empty)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic [31:0] d);
    in_valid  = iv;
    out_ready = ordy;
    in_data   = d;
  endtask

  task automatic model_clear();
    q.delete();
    wr_n = 0;
    rd_n = 0;
  endtask

  // Called at the negedge: compare against the model, then advance one clock.
  task automatic model_step();
    int          sz;
    logic        exp_full;
    logic        exp_we;
    logic        do_pop;
    logic [31:0] d;
    sz       = q.size();
    exp_full = (sz == 10);
    exp_we   = in_valid && !exp_full && !flush_tb;
    do_pop   = (sz > 0) && out_ready && !flush_tb;
    d        = in_data;
    chk("count", 32'(count), 32'(sz));
    chk("full", 32'(full), 32'(exp_full));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("in_ready", 32'(in_ready), 32'(!exp_full));
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("write_enable", 32'(fifo_write_enable), 32'(exp_we));
    chk("write_address", 32'(fifo_write_address), 32'(wr_n % 10 + 1));
    chk("read_address", 32'(fifo_read_address), 32'(rd_n % 10 + 1));
    if (sz > 0) chk("out_data", out_data, q[0]);
    @(posedge clk);
    #1;
    if (flush_tb) begin
      model_clear();
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        rd_n++;
      end
      if (exp_we) begin
        q.push_back(d);
        wr_n++;
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic ordy, input logic [31:0] d);
    drive(iv, ordy, d);
    @(negedge clk);
    model_step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, 32'(fifo_write_enable), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_waddr"}, 32'(fifo_write_address), 32'd1);
    chk({tag, "_raddr"}, 32'(fifo_read_address), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  logic [3:0] wrap_exp[5];

  initial begin
    reset    = 1'b1;
    flush_tb = 1'b0;
    drive(1'b1, 1'b0, 32'hDEAD0000);
    model_clear();

    // Fill then drain through the vector table.
    for (int i = 0; i < 11; i++) begin
      vecs[i].iv         = 1'b1;
      vecs[i].ordy       = 1'b0;
      vecs[i].data       = 32'h100 + 32'(i);
      vecs[i].exp_we     = (i < 10);
      vecs[i].exp_waddr  = (i < 10) ? 4'(i + 1) : 4'd1;
      vecs[i].exp_raddr  = 4'd1;
      vecs[i].exp_ovalid = (i > 0);
      vecs[i].exp_odata  = 32'h100;
      vecs[i].exp_count  = 4'(i);
      vecs[i].exp_full   = (i == 10);
    end
    for (int k = 0; k < 10; k++) begin
      vecs[11+k].iv         = 1'b0;
      vecs[11+k].ordy       = 1'b1;
      vecs[11+k].data       = 32'h0;
      vecs[11+k].exp_we     = 1'b0;
      vecs[11+k].exp_waddr  = 4'd1;
      vecs[11+k].exp_raddr  = 4'(k + 1);
      vecs[11+k].exp_ovalid = 1'b1;
      vecs[11+k].exp_odata  = 32'h100 + 32'(k);
      vecs[11+k].exp_count  = 4'(10 - k);
      vecs[11+k].exp_full   = (k == 0);
    end
    wrap_exp[0] = 4'd9;
    wrap_exp[1] = 4'd10;
    wrap_exp[2] = 4'd1;
    wrap_exp[3] = 4'd2;
    wrap_exp[4] = 4'd3;

    // Reset held with in_valid asserted.
    #2;
    check_reset_values("rst_hold");
    @(negedge clk);
    check_reset_values("rst_hold_neg");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].data);
      @(negedge clk);
      chk("tbl_we", 32'(fifo_write_enable), 32'(vecs[i].exp_we));
      chk("tbl_waddr", 32'(fifo_write_address), 32'(vecs[i].exp_waddr));
      chk("tbl_raddr", 32'(fifo_read_address), 32'(vecs[i].exp_raddr));
      chk("tbl_out_valid", 32'(out_valid), 32'(vecs[i].exp_ovalid));
      if (vecs[i].exp_ovalid) chk("tbl_out_data", out_data, vecs[i].exp_odata);
      chk("tbl_count", 32'(count), 32'(vecs[i].exp_count));
      chk("tbl_full", 32'(full), 32'(vecs[i].exp_full));
      model_step();
    end
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("drained_empty", 32'(empty), 32'd1);
    chk("drained_out_valid", 32'(out_valid), 32'd0);

    // Wrap across the 10 -> 1 boundary.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h200 + 32'(i));
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(k));
      @(negedge clk);
      chk("wrap_waddr", 32'(fifo_write_address), 32'(wrap_exp[k]));
      model_step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 32'h0);
      @(negedge clk);
      chk("wrap_order", out_data, 32'h300 + 32'(k));
      model_step();
    end

    // Full with simultaneous push attempt and pop.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h400 + 32'(i));
    drive(1'b1, 1'b1, 32'hAAA);
    @(negedge clk);
    chk("full_pop_we", 32'(fifo_write_enable), 32'd0);
    model_step();
    chk("full_pop_count", 32'(count), 32'd9);
    drive(1'b1, 1'b0, 32'hBBB);
    @(negedge clk);
    chk("refill_we", 32'(fifo_write_enable), 32'd1);
    chk("refill_waddr", 32'(fifo_write_address), 32'd1);
    model_step();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 32'h0);

    // Asynchronous reset in mid-cycle at count 6.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h500 + 32'(i));
    chk("pre_async_count", 32'(count), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();

`ifdef MULTIPLES_CTRL_FLUSH_EN
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h600 + 32'(i));
    flush_tb = 1'b1;
    drive(1'b1, 1'b1, 32'h6FF);
    @(negedge clk);
    chk("flush_we", 32'(fifo_write_enable), 32'd0);
    model_step();
    flush_tb = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_waddr", 32'(fifo_write_address), 32'd1);
    chk("flush_raddr", 32'(fifo_read_address), 32'd1);
`endif

    // Randomised traffic in phases with different fill/drain bias.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        int pv;
        int pr;
        pv = (ph == 0) ? 80 : ((ph == 1) ? 30 : 55);
        pr = (ph == 0) ? 30 : ((ph == 1) ? 80 : 55);
        cycle(32'($urandom_range(0, 99)) < 32'(pv), 32'($urandom_range(0, 99)) < 32'(pr), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiples_ctrl.md
# multiples_ctrl

Pointer and handshake controller that fronts the 10-slot multiples FIFO storage. It accepts 32-bit products from the upstream multiplier stage over a valid/ready handshake. It generates the storage write/read addresses over slots 1..10 with wrap-around, tracks occupancy, and presents the head word to the downstream accumulator as a first-word-fall-through valid/ready stream. The storage memory itself stays external; this block owns all sequencing.

## Interface
- DATA_WIDTH, 32, word width
- DEPTH, 10, number of storage slots
- ADDR_WIDTH, 4, storage address width
- BASE_ADDR, 1, first slot address; last slot is BASE_ADDR+DEPTH-1 (10)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream word available
- in_ready  out  1  controller can accept a word
- in_data  in  DATA_WIDTH  upstream word
- out_valid  out  1  head word available
- out_ready  in  1  downstream consumes head word
- out_data  out  DATA_WIDTH  head word
- fifo_write_enable  out  1  storage write strobe
- fifo_write_address  out  ADDR_WIDTH  storage write slot
- fifo_input_data  out  DATA_WIDTH  storage write data
- fifo_read_address  out  ADDR_WIDTH  storage read slot
- fifo_output_data  in  DATA_WIDTH  storage combinational read data
- count  out  4  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Registers: wr_ptr, rd_ptr (range BASE_ADDR..BASE_ADDR+DEPTH-1), count.
- Reset values: wr_ptr = rd_ptr = 1, count = 0. Outputs: full 0, empty 1, in_ready 1, out_valid 0, fifo_write_enable 0, fifo_write_address 1, fifo_read_address 1.
- in_ready = !full. It is registered-derived only, with no combinational path from out_ready.
- push = in_valid & in_ready. fifo_write_enable = push, fifo_write_address = wr_ptr, fifo_input_data = in_data, all combinational.
- out_valid = !empty. fifo_read_address = rd_ptr. out_data = fifo_output_data, combinational passthrough.
- pop = out_valid & out_ready.
- Pointer increment: 10 wraps to 1. Value 0 and values 11..15 are never driven.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full: push is refused even if a pop occurs the same cycle. The pop proceeds, and in_ready rises the next cycle.
- Empty: a pop is impossible. A push that cycle is accepted, and out_valid rises the next cycle.
- Data accepted with in_valid/in_ready held is the upstream's responsibility. The controller samples in_data only on push.

## Timing
- Write-to-visible latency: a word pushed in cycle N appears at out_data with out_valid in cycle N+1 when the FIFO was empty.
- Pop effect: rd_ptr advances at the edge, and the next head word is on out_data in the following cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, and stored words are abandoned (storage contents are not cleared).

## Configuration
- MULTIPLES_CTRL_FLUSH_EN defined: adds input port flush (1 bit, synchronous). When flush is high at a clock edge, wr_ptr = rd_ptr = 1 and count = 0. Any push/pop in that cycle is ignored, and fifo_write_enable is forced 0 while flush is high.
- Not defined: no flush port; occupancy is cleared only by reset.

## Structure
- Package multiples_pkg holds DATA_WIDTH, DEPTH, ADDR_WIDTH, BASE_ADDR and a next-slot wrap function. The storage block and this controller share it.
- One sub-module, multiples_slot_ptr: a wrapping slot pointer with advance input and reset to BASE_ADDR. It is instantiated twice (write, read).

## Test plan
- Reset with in_valid=1 asserted -> during reset fifo_write_enable=0, count=0, empty=1, addresses=1. After release, the first push writes slot 1.
- Push 10 words 0x100..0x109 with out_ready=0 -> writes go to slots 1..10, count reaches 10, full=1, in_ready=0. An 11th in_valid produces no write.
- Drain all 10 with out_ready=1 -> out_data reads 0x100..0x109 in order on read addresses 1..10. Then empty=1, out_valid=0.
- Wrap: push 8, pop 8, then push 5 -> write addresses 9,10,1,2,3 and read order preserved across the 10->1 boundary.
- Full with simultaneous in_valid and out_ready -> pop only, count 10->9. In the next cycle a push is accepted into the freed slot.
- Assert reset asynchronously at count=6 mid-cycle -> outputs return to reset values before the next edge. With MULTIPLES_CTRL_FLUSH_EN, flush at count=4 with push+pop the same cycle -> count=0, no write.
